// File: rtl/scaler_pkg.sv
// Shared types and helpers for the horizontal stream scaler.
// Weight 1.0 is 2^(cw-1); the phase accumulator has 5 integer bits.
package scaler_pkg;

  typedef enum logic [1:0] {
    S_FIRST,
    S_NEXT,
    S_EMIT,
    S_TAIL
  } state_t;

  function automatic int coe_one(int cw);
    return 1 << (cw - 1);
  endfunction

  function automatic int round_add(int cw);
    return 1 << (cw - 2);
  endfunction

  function automatic int acc_w(int frac_w);
    return frac_w + 5;
  endfunction

endpackage

// File: rtl/scaler_h_stream_if.sv
// Valid/ready pixel stream with start-of-line and end-of-line marks.
// Master drives payload, slave drives ready.
interface scaler_h_stream_if #(
  parameter int DATA_W = 36
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              sof;
  logic              eol;

  modport master (
    output valid, data, sof, eol,
    input  ready
  );

  modport slave (
    input  valid, data, sof, eol,
    output ready
  );
endinterface

// File: rtl/scaler_h_mac.sv
// One channel of the interpolator: multiply, sum and round, saturate.
// Three enabled register stages; y is the registered output pixel.
module scaler_h_mac
  import scaler_pkg::*;
#(
  parameter int PIXEL_WIDTH = 12,
  parameter int COE_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [PIXEL_WIDTH-1:0] a,
  input  logic [PIXEL_WIDTH-1:0] b,
  input  logic [COE_WIDTH-2:0]   w,
  output logic [PIXEL_WIDTH-1:0] y
);
  localparam int PRW = PIXEL_WIDTH + COE_WIDTH;
  localparam int SW  = PRW + 1;
  localparam int RW  = PIXEL_WIDTH + 2;
  localparam logic [COE_WIDTH-1:0] C_ONE =
    COE_WIDTH'(coe_one(COE_WIDTH));
  localparam logic [SW-1:0] RND =
    SW'(round_add(COE_WIDTH));

  logic [COE_WIDTH-1:0] c0, c1;
  logic [PRW-1:0]       m0, m1;
  logic [SW-1:0]        sum;
  logic [RW-1:0]        r;

  assign c1  = {1'b0, w};
  assign c0  = C_ONE - c1;
  assign sum = SW'(m0) + SW'(m1) + RND;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
      r  <= '0;
      y  <= '0;
    end else if (en) begin
      m0 <= PRW'(a) * PRW'(c0);
      m1 <= PRW'(b) * PRW'(c1);
      r  <= RW'(sum >> (COE_WIDTH - 1));
      y  <= (|r[RW-1:PIXEL_WIDTH]) ? '1
                                   : r[PIXEL_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/scaler_h_stream.sv
// Horizontal linear-interpolation scaler: phase FSM and stage 1 here,
// per-channel MAC stages 2-4 in scaler_h_mac.
module scaler_h_stream
  import scaler_pkg::*;
#(
  parameter int SCALE_STEP  = 4096,
  parameter int PIXEL_WIDTH = 12,
  parameter int CHANNELS    = 3,
  parameter int COE_WIDTH   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] scale_step,
  scaler_h_stream_if.slave  s,
  scaler_h_stream_if.master m
);
  localparam int FRAC_W = $clog2(SCALE_STEP);
  localparam int ACC_W  = acc_w(FRAC_W);
  localparam int PW     = PIXEL_WIDTH;
  localparam int DW     = CHANNELS * PW;
  localparam int WW     = COE_WIDTH - 1;
  localparam logic [ACC_W-1:0] ONE = ACC_W'(SCALE_STEP);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [15:0]      step_r, step_in;
  logic [DW-1:0]    p0, p1, p0_1, p1_1, y;
  logic [WW-1:0]    w1;
  logic             sof_pend, last;
  logic             en, permit, take, start, ge_one;
  logic             v1, sof1, eol1;
  logic             v2, sof2, eol2;
  logic             v3, sof3, eol3;
  logic             v4, sof4, eol4;

  assign en      = ~v4 | m.ready;
  assign ge_one  = acc >= ONE;
  assign s.ready = permit & en;
  assign take    = s.valid & s.ready;
  assign start   = take & (s.sof | (state == S_FIRST));
  assign step_in = (scale_step == 16'd0) ? 16'(SCALE_STEP)
                                         : scale_step;

  always_comb begin
    permit = 1'b0;
    unique case (state)
      S_FIRST, S_NEXT: permit = 1'b1;
      S_EMIT:          permit = ge_one & ~last;
      default:         permit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FIRST;
      acc      <= '0;
      step_r   <= 16'(SCALE_STEP);
      p0       <= '0;
      p1       <= '0;
      sof_pend <= 1'b0;
      last     <= 1'b0;
      v1       <= 1'b0;
      sof1     <= 1'b0;
      eol1     <= 1'b0;
      p0_1     <= '0;
      p1_1     <= '0;
      w1       <= '0;
    end else if (en) begin
      v1   <= 1'b0;
      sof1 <= 1'b0;
      eol1 <= 1'b0;
      // a mid-line sof drops the old line and restarts
      if (start) begin
        p0       <= s.data;
        p1       <= s.data;
        acc      <= '0;
        sof_pend <= 1'b1;
        step_r   <= step_in;
        state    <= s.eol ? S_TAIL : S_NEXT;
      end else begin
        unique case (state)
          S_FIRST: begin
          end
          S_NEXT: begin
            if (take) begin
              p1    <= s.data;
              last  <= s.eol;
              state <= S_EMIT;
            end
          end
          S_EMIT: begin
            if (!ge_one) begin
              v1       <= 1'b1;
              sof1     <= sof_pend;
              p0_1     <= p0;
              p1_1     <= p1;
              w1       <= acc[FRAC_W-1 -: WW];
              sof_pend <= 1'b0;
              acc      <= acc + ACC_W'(step_r);
            end else if (last) begin
              p0    <= p1;
              acc   <= acc - ONE;
              state <= S_TAIL;
            end else if (take) begin
              p0   <= p1;
              p1   <= s.data;
              acc  <= acc - ONE;
              last <= s.eol;
            end
          end
          S_TAIL: begin
            v1       <= 1'b1;
            sof1     <= sof_pend;
            eol1     <= 1'b1;
            p0_1     <= p1;
            p1_1     <= p1;
            w1       <= '0;
            sof_pend <= 1'b0;
            state    <= S_FIRST;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v2, sof2, eol2} <= '0;
      {v3, sof3, eol3} <= '0;
      {v4, sof4, eol4} <= '0;
    end else if (en) begin
      {v2, sof2, eol2} <= {v1, sof1, eol1};
      {v3, sof3, eol3} <= {v2, sof2, eol2};
      {v4, sof4, eol4} <= {v3, sof3, eol3};
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    scaler_h_mac #(
      .PIXEL_WIDTH(PW),
      .COE_WIDTH  (COE_WIDTH)
    ) u_mac (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .a    (p0_1[c*PW +: PW]),
      .b    (p1_1[c*PW +: PW]),
      .w    (w1),
      .y    (y[c*PW +: PW])
    );
  end

  assign m.valid = v4;
  assign m.sof   = sof4;
  assign m.eol   = eol4;
  assign m.data  = y;
endmodule

// File: tb/tb_scaler_h_stream.sv
// Bench for scaler_h_stream: vector table of lines, scoreboard queue
// of expected output pixels, plus reset and backpressure sequences.
module tb_scaler_h_stream;
  localparam int PW = 12;
  localparam int CH = 3;
  localparam int DW = PW * CH;
  localparam int NV = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] scale_step = 16'd4096;

  always #5 clk = ~clk;

  scaler_h_stream_if #(.DATA_W(DW)) s_if ();
  scaler_h_stream_if #(.DATA_W(DW)) m_if ();

  scaler_h_stream #(
    .SCALE_STEP (4096),
    .PIXEL_WIDTH(PW),
    .CHANNELS   (CH),
    .COE_WIDTH  (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scale_step(scale_step),
    .s         (s_if),
    .m         (m_if)
  );

  typedef struct {
    int step;
    int n_in;
    int pix[8];
    int n_out;
    int exp_v[8];
    bit bp;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    bit            sof;
    bit            eol;
  } exp_t;

  vec_t tv[NV];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [DW-1:0] rep(int v);
    logic [PW-1:0] p;
    p = PW'(v);
    return {CH{p}};
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h",
               name, act, req);
    end
  endtask

  task automatic send(int step, int p, bit sof, bit eol);
    bit ok;
    int guard;
    ok = 1'b0;
    guard = 0;
    @(negedge clk);
    scale_step = 16'(step);
    s_if.valid = 1'b1;
    s_if.data  = rep(p);
    s_if.sof   = sof;
    s_if.eol   = eol;
    while (!ok && guard < 1000) begin
      #4;
      ok = s_if.ready;
      @(posedge clk);
      if (!ok) @(negedge clk);
      guard++;
    end
    if (!ok) chk("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic idle();
    @(negedge clk);
    s_if.valid = 1'b0;
    s_if.sof   = 1'b0;
    s_if.eol   = 1'b0;
  endtask

  task automatic monitor(int vi, bit bp, int n);
    int            got;
    int            cyc;
    bit            hold;
    logic [DW-1:0] held;
    exp_t          e;
    got  = 0;
    cyc  = 0;
    hold = 1'b0;
    held = '0;
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      m_if.ready = bp ? (cyc % 3 == 0) : 1'b1;
      #4;
      if (hold) begin
        chk($sformatf("v%0d_hold_valid", vi),
            64'(m_if.valid), 64'd1);
        chk($sformatf("v%0d_hold_data", vi),
            64'(m_if.data), 64'(held));
      end
      hold = 1'b0;
      if (m_if.valid) begin
        if (m_if.ready) begin
          e = sb.pop_front();
          chk($sformatf("v%0d_o%0d_data", vi, got),
              64'(m_if.data), 64'(e.data));
          chk($sformatf("v%0d_o%0d_sof", vi, got),
              64'(m_if.sof), 64'(e.sof));
          chk($sformatf("v%0d_o%0d_eol", vi, got),
              64'(m_if.eol), 64'(e.eol));
          got++;
        end else begin
          hold = 1'b1;
          held = m_if.data;
        end
      end
      @(posedge clk);
      cyc++;
    end
    if (got < n)
      chk($sformatf("v%0d_out_timeout", vi),
          64'(got), 64'(n));
    @(negedge clk);
    m_if.ready = 1'b1;
  endtask

  task automatic no_extra(int vi);
    bit seen;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #4;
      if (m_if.valid) seen = 1'b1;
    end
    chk($sformatf("v%0d_no_extra", vi), 64'(seen), 64'd0);
  endtask

  task automatic run_vec(int i);
    exp_t e;
    for (int k = 0; k < tv[i].n_out; k++) begin
      e.data = rep(tv[i].exp_v[k]);
      e.sof  = (k == 0);
      e.eol  = (k == tv[i].n_out - 1);
      sb.push_back(e);
    end
    fork
      begin
        for (int k = 0; k < tv[i].n_in; k++)
          send(tv[i].step, tv[i].pix[k], k == 0,
               k == tv[i].n_in - 1);
        idle();
      end
      monitor(i, tv[i].bp, tv[i].n_out);
    join
    no_extra(i);
  endtask

  task automatic fill();
    tv[0].step  = 4096;
    tv[0].n_in  = 8;
    tv[0].pix   = '{100, 200, 300, 400, 500, 600, 700, 800};
    tv[0].n_out = 8;
    tv[0].exp_v = '{100, 200, 300, 400, 500, 600, 700, 800};
    tv[0].bp    = 1'b0;

    tv[1].step  = 2048;
    tv[1].n_in  = 4;
    tv[1].pix   = '{0, 100, 200, 300, 0, 0, 0, 0};
    tv[1].n_out = 7;
    tv[1].exp_v = '{0, 50, 100, 150, 200, 250, 300, 0};
    tv[1].bp    = 1'b0;

    tv[2].step  = 8192;
    tv[2].n_in  = 8;
    tv[2].pix   = '{10, 20, 30, 40, 50, 60, 70, 80};
    tv[2].n_out = 5;
    tv[2].exp_v = '{10, 30, 50, 70, 80, 0, 0, 0};
    tv[2].bp    = 1'b0;

    tv[3]       = tv[1];
    tv[3].bp    = 1'b1;

    tv[4].step  = 4096;
    tv[4].n_in  = 1;
    tv[4].pix   = '{4095, 0, 0, 0, 0, 0, 0, 0};
    tv[4].n_out = 1;
    tv[4].exp_v = '{4095, 0, 0, 0, 0, 0, 0, 0};
    tv[4].bp    = 1'b0;

    tv[5].step  = 2048;
    tv[5].n_in  = 2;
    tv[5].pix   = '{4095, 4095, 0, 0, 0, 0, 0, 0};
    tv[5].n_out = 3;
    tv[5].exp_v = '{4095, 4095, 4095, 0, 0, 0, 0, 0};
    tv[5].bp    = 1'b0;

    tv[6].step  = 0;
    tv[6].n_in  = 3;
    tv[6].pix   = '{5, 6, 7, 0, 0, 0, 0, 0};
    tv[6].n_out = 3;
    tv[6].exp_v = '{5, 6, 7, 0, 0, 0, 0, 0};
    tv[6].bp    = 1'b0;
  endtask

  initial begin
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.sof   = 1'b0;
    s_if.eol   = 1'b0;
    m_if.ready = 1'b1;
    fill();

    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_valid", 64'(m_if.valid), 64'd0);
    chk("rst_m_data", 64'(m_if.data), 64'd0);
    chk("rst_m_sof", 64'(m_if.sof), 64'd0);
    chk("rst_m_eol", 64'(m_if.eol), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("rst_s_ready", 64'(s_if.ready), 64'd1);

    for (int i = 0; i < NV; i++) run_vec(i);

    for (int k = 0; k < 3; k++)
      send(8192, 10 * (k + 1), k == 0, 1'b0);
    @(negedge clk);
    rst_n      = 1'b0;
    s_if.valid = 1'b0;
    s_if.sof   = 1'b0;
    #1;
    chk("midrst_m_valid", 64'(m_if.valid), 64'd0);
    chk("midrst_m_data", 64'(m_if.data), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
